ysyx_220053_wb_arbiter: RTL and testbench
=========================================

# ysyx_220053_wb_arbiter

The write-back arbiter shares the single register-file write port of the execute stage between two result producers. Requester 0 is the single-cycle ALU path. Requester 1 is the multi-cycle path (load, mul/div). Each requester has a one-entry holding buffer, and buffered writes are granted round-robin. The granted write drives a registered `wen/waddr/wdata` into the register file. The block also flags read-after-write hazards against writes that have not yet landed, so the decoder can stall.

## Interface
Parameters:
- `AW`, default 5, register address width.
- `DW`, default 64, register data width.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req0_valid` input 1: requester 0 has a write.
- `req0_ready` output 1: requester 0 write is accepted at this edge.
- `req0_addr` input AW: requester 0 destination register.
- `req0_data` input DW: requester 0 result.
- `req1_valid`, `req1_ready`, `req1_addr`, `req1_data`: same as requester 0, for requester 1.
- `rs1` input AW: decode-stage source register 1 address.
- `rs2` input AW: decode-stage source register 2 address.
- `raw_stall` output 1: a source register has a pending, unlanded write.
- `wen` output 1: register-file write enable (registered).
- `waddr` output AW: register-file write address (registered).
- `wdata` output DW: register-file write data (registered).

## Operation
- State:
  - Per requester: `buf_valid_i`, `buf_addr_i`, `buf_data_i`.
  - Round-robin pointer `last`, holding the index of the most recent grant.
  - Output registers `wen/waddr/wdata`.
- Grant, combinational from registered state only:
  - Exactly one buffer valid: grant that buffer.
  - Both buffers valid: grant `~last`.
  - Neither valid: no grant.
- `reqi_ready = ~buf_valid_i | grant_i`. There is no combinational path from `valid` to `ready`.
- Accept at an edge when `reqi_valid & reqi_ready`:
  - `req_addr != 0`: the buffer loads addr/data and `buf_valid_i` becomes 1.
  - `req_addr == 0` (x0): the handshake completes but nothing is buffered; the write is silently dropped.
- Granted buffer at an edge:
  - `wen <= 1`, `waddr <= buf_addr`, `wdata <= buf_data`, `last <= i`.
  - The buffer clears unless a new non-x0 accept reloads it at the same edge (back-to-back throughput).
- No grant at an edge: `wen <= 0`. `waddr` and `wdata` hold their values.
- `raw_stall` is 1 when either `rs1` or `rs2` is nonzero and equals any of:
  - `buf_addr_0` with `buf_valid_0` set;
  - `buf_addr_1` with `buf_valid_1` set;
  - `waddr` with `wen` set.

  No bypass is provided.
- Same-address writes from both requesters are legal. They land in grant order; the later grant wins.
- Reset, asynchronous:
  - `wen=0`, `waddr=0`, `wdata=0`.
  - Both buffers empty; `last=1`, so requester 0 wins the first contention.
  - `raw_stall=0`; both `ready=1`.
  - Reset mid-operation discards buffered and in-flight writes. No `wen` pulse follows reset deassertion until a new accept.

## Timing
- Latency from accept edge E (uncontended):
  - Grant during the cycle after E.
  - `wen` is high in the cycle after edge E+1.
  - The register file writes at edge E+2.
- Contended latency: the loser waits exactly one extra cycle.
- Throughput:
  - One write per cycle on the port.
  - A single requester with continuous `valid` sustains one write per cycle.
  - Two requesters with continuous `valid` alternate, each receiving `ready=1` every other cycle.
- `raw_stall` is valid in the same cycle `rs1`/`rs2` are presented. It deasserts in the cycle after the `wen` cycle of the matching write.

## Test plan
- Single write:
  - Stimulus: after reset, `req0` addr=5, data=0x1234 for one cycle.
  - Required: `ready0=1`; `wen=1`, `waddr=5`, `wdata=0x1234` exactly 2 cycles after the accept edge, for one cycle; `wen=0` afterwards.
- Simultaneous first requests:
  - Stimulus: `req0` (1, 0xA) and `req1` (2, 0xB) in the same cycle after reset.
  - Required: consecutive `wen` cycles, first addr 1 / 0xA, then addr 2 / 0xB.
- Sustained contention:
  - Stimulus: both requesters continuously valid for 6 cycles with distinct addresses.
  - Required: grants alternate 0,1,0,1…; each `ready` toggles; `wen` held at 1 with no gaps.
- x0 write:
  - Stimulus: `req1` addr=0, data=0xFFFF.
  - Required: `ready1=1`; `wen` never asserts; `raw_stall=0` with `rs1=0`.
- Hazard window:
  - Stimulus: `req1` addr=7 accepted; `rs1=7`, `rs2=3`.
  - Required: `raw_stall=1` from the cycle after the accept through the `wen` cycle; 0 on the next cycle.
- Reset mid-operation:
  - Stimulus: both buffers full; assert `rst` mid-cycle.
  - Required: `wen`, `waddr`, `wdata`, `raw_stall` go to 0 immediately; after release, no write occurs and both `ready=1`.

Source files
------------

// File: rtl/ysyx_220053_wb_arbiter.sv
// rtl/ysyx_220053_wb_arbiter.sv - two-requester write-back arbiter with one-entry buffers,
// round-robin grant, registered register-file write port and RAW hazard detection.
module ysyx_220053_wb_arbiter #(
  parameter int AW = 5,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          raw_stall,
  output logic          wen,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata
);

  logic          buf_valid_0_q, buf_valid_0_d;
  logic [AW-1:0] buf_addr_0_q,  buf_addr_0_d;
  logic [DW-1:0] buf_data_0_q,  buf_data_0_d;
  logic          buf_valid_1_q, buf_valid_1_d;
  logic [AW-1:0] buf_addr_1_q,  buf_addr_1_d;
  logic [DW-1:0] buf_data_1_q,  buf_data_1_d;
  logic          last_q, last_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic grant_0, grant_1;
  logic load_0, load_1;

  function automatic logic pending_hit(input logic [AW-1:0] r,
                                       input logic bv0, input logic [AW-1:0] ba0,
                                       input logic bv1, input logic [AW-1:0] ba1,
                                       input logic w,   input logic [AW-1:0] wa);
    return (r != '0) && ((bv0 && (r == ba0)) || (bv1 && (r == ba1)) || (w && (r == wa)));
  endfunction

  always_comb begin
    // Grant depends on registered state only, so ready never sees valid.
    grant_0 = buf_valid_0_q && (!buf_valid_1_q || last_q);
    grant_1 = buf_valid_1_q && (!buf_valid_0_q || !last_q);

    req0_ready = !buf_valid_0_q || grant_0;
    req1_ready = !buf_valid_1_q || grant_1;

    // x0 writes complete the handshake but never occupy a buffer.
    load_0 = req0_valid && req0_ready && (req0_addr != '0);
    load_1 = req1_valid && req1_ready && (req1_addr != '0);

    buf_valid_0_d = load_0 ? 1'b1 : (grant_0 ? 1'b0 : buf_valid_0_q);
    buf_addr_0_d  = load_0 ? req0_addr : buf_addr_0_q;
    buf_data_0_d  = load_0 ? req0_data : buf_data_0_q;
    buf_valid_1_d = load_1 ? 1'b1 : (grant_1 ? 1'b0 : buf_valid_1_q);
    buf_addr_1_d  = load_1 ? req1_addr : buf_addr_1_q;
    buf_data_1_d  = load_1 ? req1_data : buf_data_1_q;

    wen_d   = grant_0 || grant_1;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    if (grant_0) begin
      waddr_d = buf_addr_0_q;
      wdata_d = buf_data_0_q;
      last_d  = 1'b0;
    end else if (grant_1) begin
      waddr_d = buf_addr_1_q;
      wdata_d = buf_data_1_q;
      last_d  = 1'b1;
    end

    raw_stall = pending_hit(rs1, buf_valid_0_q, buf_addr_0_q, buf_valid_1_q, buf_addr_1_q,
                            wen_q, waddr_q)
             || pending_hit(rs2, buf_valid_0_q, buf_addr_0_q, buf_valid_1_q, buf_addr_1_q,
                            wen_q, waddr_q);
  end

  // last resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_0_q <= 1'b0;
      buf_addr_0_q  <= '0;
      buf_data_0_q  <= '0;
      buf_valid_1_q <= 1'b0;
      buf_addr_1_q  <= '0;
      buf_data_1_q  <= '0;
      last_q        <= 1'b1;
      wen_q         <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
    end else begin
      buf_valid_0_q <= buf_valid_0_d;
      buf_addr_0_q  <= buf_addr_0_d;
      buf_data_0_q  <= buf_data_0_d;
      buf_valid_1_q <= buf_valid_1_d;
      buf_addr_1_q  <= buf_addr_1_d;
      buf_data_1_q  <= buf_data_1_d;
      last_q        <= last_d;
      wen_q         <= wen_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
    end
  end

  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_ysyx_220053_wb_arbiter.sv
// tb/tb_ysyx_220053_wb_arbiter.sv - directed vector table bench for the write-back arbiter.
module tb_ysyx_220053_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic [AW-1:0] rs1 = '0, rs2 = '0;
  logic          raw_stall, wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  always #5 clk = ~clk;

  ysyx_220053_wb_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .rs1(rs1), .rs2(rs2), .raw_stall(raw_stall),
    .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  typedef struct {
    logic          rst;
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic          e_rdy0;
    logic          e_rdy1;
    logic          e_stall;
    logic          e_wen;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic r, input logic v0, input int a0, input logic [DW-1:0] d0,
                              input logic v1, input int a1, input logic [DW-1:0] d1,
                              input int s1, input int s2,
                              input logic rd0, input logic rd1, input logic st,
                              input logic w, input int wa, input logic [DW-1:0] wd);
    vec_t t;
    t.rst = r; t.v0 = v0; t.a0 = AW'(a0); t.d0 = d0;
    t.v1 = v1; t.a1 = AW'(a1); t.d1 = d1;
    t.r1 = AW'(s1); t.r2 = AW'(s2);
    t.e_rdy0 = rd0; t.e_rdy1 = rd1; t.e_stall = st;
    t.e_wen = w; t.e_waddr = AW'(wa); t.e_wdata = wd;
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input logic rd0, input logic rd1, input logic st,
                               input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    check("req0_ready", idx, DW'(req0_ready), DW'(rd0));
    check("req1_ready", idx, DW'(req1_ready), DW'(rd1));
    check("raw_stall",  idx, DW'(raw_stall),  DW'(st));
    check("wen",        idx, DW'(wen),        DW'(w));
    check("waddr",      idx, DW'(waddr),      DW'(wa));
    check("wdata",      idx, wdata,           wd);
  endtask

  task automatic run_vec(input int i);
    @(posedge clk);
    #1;
    rst        = vecs[i].rst;
    req0_valid = vecs[i].v0; req0_addr = vecs[i].a0; req0_data = vecs[i].d0;
    req1_valid = vecs[i].v1; req1_addr = vecs[i].a1; req1_data = vecs[i].d1;
    rs1 = vecs[i].r1; rs2 = vecs[i].r2;
    @(negedge clk);
    check_outputs(i, vecs[i].e_rdy0, vecs[i].e_rdy1, vecs[i].e_stall,
                  vecs[i].e_wen, vecs[i].e_waddr, vecs[i].e_wdata);
  endtask

  int split;

  initial begin
    // reset state
    vecs.push_back(mk(1, 0,0,0,     0,0,0,     0,0, 1,1,0, 0,0,0));
    // single write: wen two edges after accept, one cycle only
    vecs.push_back(mk(0, 1,5,'h1234, 0,0,0,    0,0, 1,1,0, 0,0,0));
    vecs.push_back(mk(0, 0,0,0,     0,0,0,     0,0, 1,1,0, 0,0,0));
    vecs.push_back(mk(0, 0,0,0,     0,0,0,     0,0, 1,1,0, 1,5,'h1234));
    vecs.push_back(mk(0, 0,0,0,     0,0,0,     0,0, 1,1,0, 0,5,'h1234));
    // simultaneous first requests after reset: requester 0 first
    vecs.push_back(mk(1, 0,0,0,     0,0,0,     0,0, 1,1,0, 0,0,0));
    vecs.push_back(mk(0, 1,1,'hA,   1,2,'hB,   0,0, 1,1,0, 0,0,0));
    vecs.push_back(mk(0, 0,0,0,     0,0,0,     0,0, 1,0,0, 0,0,0));
    vecs.push_back(mk(0, 0,0,0,     0,0,0,     0,0, 1,1,0, 1,1,'hA));
    vecs.push_back(mk(0, 0,0,0,     0,0,0,     0,0, 1,1,0, 1,2,'hB));
    vecs.push_back(mk(0, 0,0,0,     0,0,0,     0,0, 1,1,0, 0,2,'hB));
    // sustained contention: alternating grants, no gaps in wen
    vecs.push_back(mk(0, 1,10,'hC10, 1,20,'hC20, 0,0, 1,1,0, 0,2,'hB));
    vecs.push_back(mk(0, 1,11,'hC11, 1,21,'hC21, 0,0, 1,0,0, 0,2,'hB));
    vecs.push_back(mk(0, 1,12,'hC12, 1,21,'hC21, 0,0, 0,1,0, 1,10,'hC10));
    vecs.push_back(mk(0, 1,12,'hC12, 1,22,'hC22, 0,0, 1,0,0, 1,20,'hC20));
    vecs.push_back(mk(0, 1,13,'hC13, 1,22,'hC22, 0,0, 0,1,0, 1,11,'hC11));
    vecs.push_back(mk(0, 1,13,'hC13, 1,23,'hC23, 0,0, 1,0,0, 1,21,'hC21));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 0,1,0, 1,12,'hC12));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 1,1,0, 1,22,'hC22));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 1,1,0, 1,13,'hC13));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 1,1,0, 0,13,'hC13));
    // x0 write is dropped
    vecs.push_back(mk(0, 0,0,0,      1,0,'hFFFF, 0,0, 1,1,0, 0,13,'hC13));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 1,1,0, 0,13,'hC13));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 1,1,0, 0,13,'hC13));
    // hazard window on register 7 through the wen cycle
    vecs.push_back(mk(0, 0,0,0,      1,7,'h77,   7,3, 1,1,0, 0,13,'hC13));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,      7,3, 1,1,1, 0,13,'hC13));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,      3,7, 1,1,1, 1,7,'h77));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,      7,3, 1,1,0, 0,7,'h77));
    // fill both buffers ahead of a mid-cycle reset
    vecs.push_back(mk(0, 1,3,'h33,   1,4,'h44,   3,0, 1,1,0, 0,7,'h77));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,      3,0, 1,0,1, 0,7,'h77));
    split = vecs.size();
    // after reset release: nothing lands, both ready
    vecs.push_back(mk(0, 0,0,0,      0,0,0,      4,0, 1,1,0, 0,0,0));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,      4,0, 1,1,0, 0,0,0));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,      4,0, 1,1,0, 0,0,0));

    for (int i = 0; i < split; i++) run_vec(i);

    // mid-cycle asynchronous reset while a write is on the port and buffer 1 is full
    @(posedge clk);
    #1;
    rs1 = 4; rs2 = 0;
    #2;
    check_outputs(100, 1'b1, 1'b1, 1'b1, 1'b1, AW'(3), DW'('h33));
    rst = 1'b1;
    #1;
    check_outputs(101, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    #1;
    rst = 1'b0;

    for (int i = split; i < vecs.size(); i++) run_vec(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
